// File: rtl/alu_seg_display.sv
// alu_seg_display: drives an 8-digit multiplexed seven-segment display from an
// 8-bit ALU result. Digits 0/1 show the value in hex, digits 4..6 show it in
// decimal (double-dabble conversion), digits 2, 3 and 7 stay dark.
module alu_seg_display #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result,
    output logic [7:0] seg_cs,
    output logic [7:0] seg_out,
    output logic       conv_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Hex nibble to active-high segment pattern (bit0=a .. bit6=g, dp off).
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'h3F;
            4'h1:    seg = 8'h06;
            4'h2:    seg = 8'h5B;
            4'h3:    seg = 8'h4F;
            4'h4:    seg = 8'h66;
            4'h5:    seg = 8'h6D;
            4'h6:    seg = 8'h7D;
            4'h7:    seg = 8'h07;
            4'h8:    seg = 8'h7F;
            4'h9:    seg = 8'h6F;
            4'hA:    seg = 8'h77;
            4'hB:    seg = 8'h7C;
            4'hC:    seg = 8'h39;
            4'hD:    seg = 8'h5E;
            4'hE:    seg = 8'h79;
            4'hF:    seg = 8'h71;
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
        logic [3:0] adj;
        if (nib >= 4'd5) begin
            adj = nib + 4'd3;
        end else begin
            adj = nib;
        end
        return adj;
    endfunction

    logic [7:0]  r_res_q;
    logic [7:0]  r_conv_src;
    logic [7:0]  r_cap;
    logic [7:0]  r_shift;
    logic [11:0] r_bcd;
    logic [3:0]  r_bit_cnt;
    logic [3:0]  r_ones;
    logic [3:0]  r_tens;
    logic [3:0]  r_hund;
    conv_state_t r_state;
    conv_state_t w_next_state;
    logic [11:0] w_bcd_adj;
    logic [19:0] w_dabble;
    logic [15:0] r_scan_cnt;
    logic [2:0]  r_digit_idx;
    logic [7:0]  w_digit_seg;
    logic [7:0]  r_seg_cs;
    logic [7:0]  r_seg_out;
    logic        r_conv_busy;

    // Register the ALU result every clock; everything downstream works on r_res_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_q <= 8'd0;
        end else begin
            r_res_q <= result;
        end
    end

    // Conversion FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Conversion FSM next state: start when the held value differs from the last
    // converted one, run 8 shifts, then one DONE cycle to publish the digits.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (r_res_q != r_conv_src) begin
                    w_next_state = SHIFT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SHIFT: begin
                if (r_bit_cnt == 4'd1) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = SHIFT;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // One double-dabble step: correct each BCD nibble, then shift {bcd, bin} left.
    always_comb begin
        w_bcd_adj = {bcd_adjust(r_bcd[11:8]), bcd_adjust(r_bcd[7:4]), bcd_adjust(r_bcd[3:0])};
        w_dabble  = {w_bcd_adj, r_shift} << 5'd1;
    end

    // Conversion datapath: capture in IDLE, shift in SHIFT, publish in DONE.
    // The captured copy keeps the running conversion immune to result changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap      <= 8'd0;
            r_shift    <= 8'd0;
            r_bcd      <= 12'd0;
            r_bit_cnt  <= 4'd0;
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_hund     <= 4'd0;
            r_conv_src <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_res_q != r_conv_src) begin
                        r_cap     <= r_res_q;
                        r_shift   <= r_res_q;
                        r_bcd     <= 12'd0;
                        r_bit_cnt <= 4'd8;
                    end
                end
                SHIFT: begin
                    r_bcd     <= w_dabble[19:8];
                    r_shift   <= w_dabble[7:0];
                    r_bit_cnt <= r_bit_cnt - 4'd1;
                end
                DONE: begin
                    r_hund     <= r_bcd[11:8];
                    r_tens     <= r_bcd[7:4];
                    r_ones     <= r_bcd[3:0];
                    r_conv_src <= r_cap;
                end
                default: begin
                    r_bit_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Scan timer: each digit stays selected for SCAN_DIV clocks, digits cycle 0..7.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt  <= 16'd0;
            r_digit_idx <= 3'd0;
        end else if (r_scan_cnt == (SCAN_DIV - 16'd1)) begin
            r_scan_cnt  <= 16'd0;
            r_digit_idx <= r_digit_idx + 3'd1;
        end else begin
            r_scan_cnt  <= r_scan_cnt + 16'd1;
        end
    end

    // Segment pattern for the currently selected digit, with leading-zero blanking.
    always_comb begin
        w_digit_seg = 8'h00;
        case (r_digit_idx)
            3'd0: w_digit_seg = hex_to_seg(r_res_q[3:0]);
            3'd1: w_digit_seg = hex_to_seg(r_res_q[7:4]);
            3'd4: w_digit_seg = hex_to_seg(r_ones);
            3'd5: begin
                if ((r_hund == 4'd0) && (r_tens == 4'd0)) begin
                    w_digit_seg = 8'h00;
                end else begin
                    w_digit_seg = hex_to_seg(r_tens);
                end
            end
            3'd6: begin
                if (r_hund == 4'd0) begin
                    w_digit_seg = 8'h00;
                end else begin
                    w_digit_seg = hex_to_seg(r_hund);
                end
            end
            default: w_digit_seg = 8'h00;
        endcase
    end

    // Output registers: select and pattern move together on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_cs    <= 8'h00;
            r_seg_out   <= 8'h00;
            r_conv_busy <= 1'b0;
        end else begin
            r_seg_cs    <= 8'd1 << r_digit_idx;
            r_seg_out   <= w_digit_seg;
            r_conv_busy <= (w_next_state != IDLE);
        end
    end

    assign seg_cs    = r_seg_cs;
    assign seg_out   = r_seg_out;
    assign conv_busy = r_conv_busy;

endmodule
